// File: rtl/sm_accum_seq.sv
// sm_accum_seq: reduces KLEN sign-magnitude operands plus a bias into one sum
// using a single time-shared 16-bit sign-magnitude adder. One start per output
// point, KLEN accepted input beats, one result presented with a valid/ready
// handshake. A start during the output handshake chains straight into the next
// reduction without an idle cycle.
module sm_accum_seq #(
  parameter int KLEN     = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic        busy
);

  localparam int CW = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(KLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_ovf_q, out_ovf_d;

  logic          beat;
  logic [16:0]   add_res;
  logic [15:0]   acc_next;
  logic          ovf_next;

  // Sign-magnitude add. Returns {magnitude carry, result}. Equal magnitudes
  // with opposite signs cancel to -0 (16'h8000), matching the shared adder.
  function automatic logic [16:0] sm_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sum_mag;
    logic [15:0] r;
    logic        carry;
    sum_mag = '0;
    carry   = 1'b0;
    if (a[15] == b[15]) begin
      sum_mag = {1'b0, a[14:0]} + {1'b0, b[14:0]};
      carry   = sum_mag[15];
      r       = {a[15], sum_mag[14:0]};
    end else if (a[14:0] > b[14:0]) begin
      r = {a[15], a[14:0] - b[14:0]};
    end else if (a[14:0] < b[14:0]) begin
      r = {b[15], b[14:0] - a[14:0]};
    end else begin
      r = 16'h8000;
    end
    return {carry, r};
  endfunction

  // Clamp the magnitude on overflow when saturation is enabled; otherwise keep
  // the wrapped adder result.
  function automatic logic [15:0] sat_mag(input logic [15:0] sum, input logic carry);
    if (SATURATE && carry) begin
      return {sum[15], 15'h7FFF};
    end
    return sum;
  endfunction

  // Present -0 as +0 so the consumer never sees 16'h8000.
  function automatic logic [15:0] norm_zero(input logic [15:0] v);
    return (v == 16'h8000) ? 16'h0000 : v;
  endfunction

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  assign beat     = in_valid & in_ready;
  assign add_res  = sm_add(acc_q, in_data);
  assign acc_next = sat_mag(add_res[15:0], add_res[16]);
  assign ovf_next = ovf_q | add_res[16];

  // Next-state and datapath update; clr overrides every state decision.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACC;
          acc_d   = bias;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ACC: begin
        if (beat) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CW'(1);
          ovf_d = ovf_next;
          if (cnt_q == CNT_LAST) begin
            state_d    = S_OUT;
            out_data_d = norm_zero(acc_next);
            out_ovf_d  = ovf_next;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (start) begin
            state_d = S_ACC;
            acc_d   = bias;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  // State, accumulator and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule
